// File: rtl/fc8_vram_arbiter.sv
// Fixed-priority VRAM arbiter: graphics fetcher first, CPU promoted after a bounded wait.
// Optional statistics counters are enabled with FC8_VRAM_ARB_STATS_EN.
module fc8_vram_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 8,
   parameter int CPU_MAX_WAIT = 8
) (
   input  logic              master_clk,
   input  logic              master_rst_n,
   input  logic              gfx_req,
   input  logic [ADDR_W-1:0] gfx_addr,
   output logic              gfx_ack,
   output logic [DATA_W-1:0] gfx_rdata,
   output logic              gfx_rdata_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rdata_valid,
   output logic              vram_en,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [DATA_W-1:0] vram_wdata,
   input  logic [DATA_W-1:0] vram_rdata
`ifdef FC8_VRAM_ARB_STATS_EN
   ,
   output logic [15:0]       stat_cpu_stall,
   output logic [15:0]       stat_gfx_grants
`endif
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_GFX  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_e;

   localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);

   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic              vram_en_q, vram_en_d;
   logic              vram_we_q, vram_we_d;
   logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
   logic [DATA_W-1:0] vram_wdata_q, vram_wdata_d;
   owner_e            own1_q, own1_d;
   owner_e            own2_q, own2_d;
   logic [DATA_W-1:0] gfx_rdata_q, gfx_rdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic              gfx_valid_q, gfx_valid_d;
   logic              cpu_valid_q, cpu_valid_d;
   logic              starve;

   // Grant decision: graphics by default, CPU when idle graphics or starved
   always_comb begin
      starve  = (wait_cnt_q >= MAX_WAIT);
      cpu_ack = cpu_req & (~gfx_req | starve);
      gfx_ack = gfx_req & ~cpu_ack;
   end

   always_comb begin
      wait_cnt_d   = wait_cnt_q;
      vram_en_d    = gfx_ack | cpu_ack;
      vram_we_d    = cpu_ack & cpu_we;
      vram_addr_d  = vram_addr_q;
      vram_wdata_d = vram_wdata_q;
      own1_d       = OWN_NONE;
      own2_d       = own1_q;
      gfx_rdata_d  = gfx_rdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      gfx_valid_d  = (own2_q == OWN_GFX);
      cpu_valid_d  = (own2_q == OWN_CPU);

      if (cpu_ack || !cpu_req) begin
         wait_cnt_d = 8'd0;
      end else if (wait_cnt_q != 8'hFF) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end

      if (cpu_ack) begin
         vram_addr_d  = cpu_addr;
         vram_wdata_d = cpu_wdata;
         own1_d       = cpu_we ? OWN_NONE : OWN_CPU;
      end else if (gfx_ack) begin
         vram_addr_d  = gfx_addr;
         vram_wdata_d = '0;
         own1_d       = OWN_GFX;
      end

      // Synchronous VRAM data lines up with the second pipeline slot
      if (own2_q == OWN_GFX) gfx_rdata_d = vram_rdata;
      if (own2_q == OWN_CPU) cpu_rdata_d = vram_rdata;
   end

   always_ff @(posedge master_clk or negedge master_rst_n) begin
      if (!master_rst_n) begin
         wait_cnt_q   <= 8'd0;
         vram_en_q    <= 1'b0;
         vram_we_q    <= 1'b0;
         vram_addr_q  <= '0;
         vram_wdata_q <= '0;
         own1_q       <= OWN_NONE;
         own2_q       <= OWN_NONE;
         gfx_rdata_q  <= '0;
         cpu_rdata_q  <= '0;
         gfx_valid_q  <= 1'b0;
         cpu_valid_q  <= 1'b0;
      end else begin
         wait_cnt_q   <= wait_cnt_d;
         vram_en_q    <= vram_en_d;
         vram_we_q    <= vram_we_d;
         vram_addr_q  <= vram_addr_d;
         vram_wdata_q <= vram_wdata_d;
         own1_q       <= own1_d;
         own2_q       <= own2_d;
         gfx_rdata_q  <= gfx_rdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         gfx_valid_q  <= gfx_valid_d;
         cpu_valid_q  <= cpu_valid_d;
      end
   end

   assign vram_en         = vram_en_q;
   assign vram_we         = vram_we_q;
   assign vram_addr       = vram_addr_q;
   assign vram_wdata      = vram_wdata_q;
   assign gfx_rdata       = gfx_rdata_q;
   assign cpu_rdata       = cpu_rdata_q;
   assign gfx_rdata_valid = gfx_valid_q;
   assign cpu_rdata_valid = cpu_valid_q;

`ifdef FC8_VRAM_ARB_STATS_EN
   logic [15:0] stat_cpu_stall_q, stat_cpu_stall_d;
   logic [15:0] stat_gfx_grants_q, stat_gfx_grants_d;

   always_comb begin
      stat_cpu_stall_d  = stat_cpu_stall_q;
      stat_gfx_grants_d = stat_gfx_grants_q;
      if (cpu_req && !cpu_ack && stat_cpu_stall_q != 16'hFFFF)
         stat_cpu_stall_d = stat_cpu_stall_q + 16'd1;
      if (gfx_ack && stat_gfx_grants_q != 16'hFFFF)
         stat_gfx_grants_d = stat_gfx_grants_q + 16'd1;
   end

   always_ff @(posedge master_clk or negedge master_rst_n) begin
      if (!master_rst_n) begin
         stat_cpu_stall_q  <= 16'd0;
         stat_gfx_grants_q <= 16'd0;
      end else begin
         stat_cpu_stall_q  <= stat_cpu_stall_d;
         stat_gfx_grants_q <= stat_gfx_grants_d;
      end
   end

   assign stat_cpu_stall  = stat_cpu_stall_q;
   assign stat_gfx_grants = stat_gfx_grants_q;
`endif

endmodule

// File: tb/tb_fc8_vram_arbiter.sv
// Scoreboard bench for fc8_vram_arbiter with a behavioural synchronous VRAM.
// Statistics checks are compiled in when FC8_VRAM_ARB_STATS_EN is defined.
module tb_fc8_vram_arbiter;

   logic        master_clk = 1'b0;
   logic        master_rst_n = 1'b0;
   logic        gfx_req = 1'b0;
   logic [15:0] gfx_addr = '0;
   logic        gfx_ack;
   logic [7:0]  gfx_rdata;
   logic        gfx_rdata_valid;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        cpu_rdata_valid;
   logic        vram_en;
   logic        vram_we;
   logic [15:0] vram_addr;
   logic [7:0]  vram_wdata;
   logic [7:0]  vram_rdata = '0;
`ifdef FC8_VRAM_ARB_STATS_EN
   logic [15:0] stat_cpu_stall;
   logic [15:0] stat_gfx_grants;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t gfx_q[$];
   exp_t cpu_q[$];
   exp_t gfx_e;
   exp_t cpu_e;

   logic [7:0] mem [0:65535];

   fc8_vram_arbiter #(.ADDR_W(16), .DATA_W(8), .CPU_MAX_WAIT(8)) dut (
      .master_clk      (master_clk),
      .master_rst_n    (master_rst_n),
      .gfx_req         (gfx_req),
      .gfx_addr        (gfx_addr),
      .gfx_ack         (gfx_ack),
      .gfx_rdata       (gfx_rdata),
      .gfx_rdata_valid (gfx_rdata_valid),
      .cpu_req         (cpu_req),
      .cpu_we          (cpu_we),
      .cpu_addr        (cpu_addr),
      .cpu_wdata       (cpu_wdata),
      .cpu_ack         (cpu_ack),
      .cpu_rdata       (cpu_rdata),
      .cpu_rdata_valid (cpu_rdata_valid),
      .vram_en         (vram_en),
      .vram_we         (vram_we),
      .vram_addr       (vram_addr),
      .vram_wdata      (vram_wdata),
      .vram_rdata      (vram_rdata)
`ifdef FC8_VRAM_ARB_STATS_EN
      ,
      .stat_cpu_stall  (stat_cpu_stall),
      .stat_gfx_grants (stat_gfx_grants)
`endif
   );

   always #5 master_clk = ~master_clk;

   always @(posedge master_clk) cyc <= cyc + 1;

   function automatic logic [7:0] patt(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   // Behavioural single-port VRAM with one-cycle synchronous read
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = patt(16'(i));
   end

   always @(posedge master_clk) begin
      if (vram_en) begin
         if (vram_we) mem[vram_addr] <= vram_wdata;
         else vram_rdata <= mem[vram_addr];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic gr, input logic [15:0] ga, input logic cr,
                                input logic cwe, input logic [15:0] ca, input logic [7:0] cd);
      gfx_req   = gr;
      gfx_addr  = ga;
      cpu_req   = cr;
      cpu_we    = cwe;
      cpu_addr  = ca;
      cpu_wdata = cd;
   endtask

   // One request cycle: drive, check grants, queue expected returns, cross the edge
   task automatic issueCycle(input logic gr, input logic [15:0] ga, input logic cr,
                             input logic cwe, input logic [15:0] ca, input logic [7:0] cd,
                             input logic eg, input logic ec, input logic [7:0] cexp,
                             input string tag);
      exp_t e;
      @(negedge master_clk);
      applyStimulus(gr, ga, cr, cwe, ca, cd);
      #1;
      checkOutput({tag, "_gfx_ack"}, 32'(gfx_ack), 32'(eg));
      checkOutput({tag, "_cpu_ack"}, 32'(cpu_ack), 32'(ec));
      if (eg) begin
         e.data = patt(ga);
         e.cyc  = cyc + 1;
         gfx_q.push_back(e);
      end
      if (ec && !cwe) begin
         e.data = cexp;
         e.cyc  = cyc + 1;
         cpu_q.push_back(e);
      end
      @(posedge master_clk);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge master_clk);
         applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
      end
   endtask

   // Monitor: every valid pulse must match the head of its queue, data and cycle
   always @(negedge master_clk) begin
      if (gfx_rdata_valid) begin
         if (gfx_q.size() == 0) begin
            checkOutput("gfx_unexpected_valid", 32'd1, 32'd0);
         end else begin
            gfx_e = gfx_q.pop_front();
            checkOutput("gfx_rdata", 32'(gfx_rdata), 32'(gfx_e.data));
            checkOutput("gfx_valid_cycle", 32'(cyc), 32'(gfx_e.cyc + 2));
         end
      end
      if (cpu_rdata_valid) begin
         if (cpu_q.size() == 0) begin
            checkOutput("cpu_unexpected_valid", 32'd1, 32'd0);
         end else begin
            cpu_e = cpu_q.pop_front();
            checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(cpu_e.data));
            checkOutput("cpu_valid_cycle", 32'(cyc), 32'(cpu_e.cyc + 2));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog_timeout actual=%0d required=finished", cyc);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [15:0] ga;
      logic [15:0] ca;
      logic        ec;

      // Reset state
      #1;
      checkOutput("rst_vram_en", 32'(vram_en), 32'd0);
      checkOutput("rst_vram_we", 32'(vram_we), 32'd0);
      checkOutput("rst_vram_addr", 32'(vram_addr), 32'd0);
      checkOutput("rst_vram_wdata", 32'(vram_wdata), 32'd0);
      checkOutput("rst_gfx_rdata", 32'(gfx_rdata), 32'd0);
      checkOutput("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      checkOutput("rst_valids", 32'({gfx_rdata_valid, cpu_rdata_valid}), 32'd0);
      checkOutput("rst_acks", 32'({gfx_ack, cpu_ack}), 32'd0);
      repeat (2) @(negedge master_clk);
      master_rst_n = 1'b1;

      // Ten idle cycles after release
      for (int i = 0; i < 10; i++) begin
         @(negedge master_clk);
         applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
         #1;
         checkOutput("idle_vram_en", 32'(vram_en), 32'd0);
      end

      // CPU write then read-back of the same location
      issueCycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h2000, 8'h03, 1'b0, 1'b1, 8'h00, "cpu_wr");
      #1;
      checkOutput("wr_vram_en", 32'(vram_en), 32'd1);
      checkOutput("wr_vram_we", 32'(vram_we), 32'd1);
      checkOutput("wr_vram_addr", 32'(vram_addr), 32'h2000);
      checkOutput("wr_vram_wdata", 32'(vram_wdata), 32'h03);
      issueCycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h2000, 8'h00, 1'b0, 1'b1, 8'h03, "cpu_rd");
      #1;
      checkOutput("rd_vram_en", 32'(vram_en), 32'd1);
      checkOutput("rd_vram_we", 32'(vram_we), 32'd0);
      idleCycles(5);

      // Simultaneous requests with an empty wait counter
      issueCycle(1'b1, 16'h1100, 1'b1, 1'b0, 16'h2000, 8'h00, 1'b1, 1'b0, 8'h03, "sim0");
      #1;
      checkOutput("sim_gfx_we", 32'(vram_we), 32'd0);
      checkOutput("sim_gfx_wdata", 32'(vram_wdata), 32'd0);
      issueCycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h2000, 8'h00, 1'b0, 1'b1, 8'h03, "sim1");
      idleCycles(5);

      // Starvation: eight graphics grants, one CPU grant, repeated twice
      ga = 16'h1000;
      ca = 16'h3000;
      for (int i = 0; i < 18; i++) begin
         ec = (i == 8) || (i == 17);
         issueCycle(1'b1, ga, 1'b1, 1'b0, ca, 8'h00, ~ec, ec, patt(ca), $sformatf("starve%0d", i));
`ifdef FC8_VRAM_ARB_STATS_EN
         if (i == 7) begin
            #1;
            checkOutput("stat_cpu_stall", 32'(stat_cpu_stall), 32'd8);
            checkOutput("stat_gfx_grants", 32'(stat_gfx_grants), 32'd8);
         end
`endif
         if (ec) ca = ca + 16'd1;
         else ga = ga + 16'd1;
      end
      idleCycles(5);

      // Reset while a CPU read is in flight
      issueCycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h2000, 8'h00, 1'b0, 1'b1, 8'h03, "rst_rd");
      @(negedge master_clk);
      master_rst_n = 1'b0;
      cpu_q.delete();
      applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
      #1;
      checkOutput("midrst_vram_en", 32'(vram_en), 32'd0);
      checkOutput("midrst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      repeat (2) @(posedge master_clk);
      #2;
      master_rst_n = 1'b1;
      issueCycle(1'b1, 16'h0042, 1'b0, 1'b0, 16'h0, 8'h00, 1'b1, 1'b0, 8'h00, "post_rst");
      idleCycles(6);
      #1;
      checkOutput("post_rst_cpu_rdata", 32'(cpu_rdata), 32'd0);

      checkOutput("gfx_queue_drained", 32'(gfx_q.size()), 32'd0);
      checkOutput("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
